branch_predict_unit: RTL and testbench
======================================

# branch_predict_unit

Parametrised successor to the combinational branch comparator: resolves conditional branches in EX and keeps a table of 2-bit saturating counters for IF-stage taken/not-taken prediction. It registers one resolution per cycle, flags mispredictions for pipeline flush, and maintains branch and mispredict statistics counters. It sits between IF (prediction lookup) and EX (resolution) in the MIPS pipeline.

## Interface
- WIDTH, 32, operand width of A/B
- ADDR_WIDTH, 32, PC width
- IDX_BITS, 4, log2 of predictor table depth (16 entries)
- CNT_WIDTH, 16, width of statistics counters
- Clk  input  1  rising-edge clock
- Rst  input  1  reset; one clock, asynchronous, active-high
- IF_PC  input  ADDR_WIDTH  fetch PC for prediction lookup
- IF_Predict_Taken  output  1  combinational: MSB of counter at IF_PC index
- EX_Valid  input  1  EX holds an instruction to resolve this cycle
- EX_BranchType  input  4  branch code (below)
- EX_A, EX_B  input  WIDTH  operands, two's complement
- EX_PC  input  ADDR_WIDTH  PC of the EX instruction
- EX_Predicted_Taken  input  1  prediction carried down from IF
- Cnt_Clr  input  1  synchronous clear of statistics counters
- Res_Valid  output  1  one-cycle pulse: a resolution is presented
- Res_Taken  output  1  actual outcome
- Res_Mispredict  output  1  outcome differs from EX_Predicted_Taken; drives flush
- Branch_Count  output  CNT_WIDTH  resolved conditional branches
- Mispredict_Count  output  CNT_WIDTH  mispredicted conditional branches

## Operation
- Codes: 0011 bgez (A>=0), 0100 beq (A==B), 0101 bne (A!=B), 0110 bgtz (A>0), 0111 blez (A<=0), 1000 bltz (A<0), 1001 jump. All other codes are non-branch.
- All compares signed on full WIDTH; B is used only by beq/bne.
- Index = PC[IDX_BITS+1:2] (word-aligned) for both IF lookup and EX update.
- Counter states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; predict taken when MSB=1.
- Conditional branch with EX_Valid=1: taken increments counter, saturating at 11; not-taken decrements, saturating at 00; Branch_Count +1; Mispredict_Count +1 if mispredicted.
- Jump (1001) with EX_Valid=1: Res_Valid=1, Res_Taken=1, Res_Mispredict=0; table and counters untouched.
- Non-branch code or EX_Valid=0: Res_Valid=0, Res_Taken=0, Res_Mispredict=0; no table or counter change.
- Statistics counters wrap modulo 2^CNT_WIDTH. Cnt_Clr has priority over a same-cycle increment (result 0).

## Timing
- Reset: Res_Valid=0, Res_Taken=0, Res_Mispredict=0, both counters 0, every table entry 01; IF_Predict_Taken therefore reads 0.
- Reset asserted mid-operation clears everything immediately; an in-flight EX resolution is discarded.
- EX inputs are sampled at rising edge N. Res_* are valid during cycle N+1 (latency 1) and return to 0 at N+2 unless another resolution is sampled.
- The table entry and statistics counters update at edge N. An IF lookup of the same index during cycle N (before the edge) sees the old value; from cycle N+1 it sees the new value. There is no bypass.
- Back-to-back resolutions to the same index, one per cycle, each see the value written by the previous one.
- Throughput: one resolution per cycle; no stall or backpressure.

## Test plan
- Reset, then IF_PC=0x40 -> IF_Predict_Taken=0; all outputs 0.
- beq A=-9, B=-9, predicted 0, PC=0x40 -> next cycle Res_Valid=1, Res_Taken=1, Res_Mispredict=1; Branch_Count=1, Mispredict_Count=1; IF_PC=0x40 now predicts 1 (entry 10).
- Three consecutive taken bgez A=47 at PC=0x44, then one not-taken bltz A=101 at PC=0x44 -> entry goes 01->10->11->11->10; prediction stays 1 throughout.
- Aliasing: PC=0x04 and PC=0x44 share index 1 with IDX_BITS=4 -> an update via one is visible to the other.
- jump 1001 predicted 0 -> Res_Taken=1, Res_Mispredict=0; counters unchanged. Code 0000 with EX_Valid=1 -> Res_Valid=0.
- CNT_WIDTH=4, 16 mispredicted bne -> both counters wrap to 0. Cnt_Clr asserted with a concurrent branch -> counters 0 while the table still updates. Rst asserted mid-stream -> asynchronous clear and table back to 01.

Source files
------------

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - EX branch resolution with a 2-bit saturating-counter predictor table
// Resolves EX branches, updates the IF prediction table and keeps branch/mispredict statistics.
module branch_predict_unit #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_BITS   = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [ADDR_WIDTH-1:0] IF_PC,
  output logic                  IF_Predict_Taken,
  input  logic                  EX_Valid,
  input  logic [3:0]            EX_BranchType,
  input  logic [WIDTH-1:0]      EX_A,
  input  logic [WIDTH-1:0]      EX_B,
  input  logic [ADDR_WIDTH-1:0] EX_PC,
  input  logic                  EX_Predicted_Taken,
  input  logic                  Cnt_Clr,
  output logic                  Res_Valid,
  output logic                  Res_Taken,
  output logic                  Res_Mispredict,
  output logic [CNT_WIDTH-1:0]  Branch_Count,
  output logic [CNT_WIDTH-1:0]  Mispredict_Count
);

  localparam int DEPTH = 1 << IDX_BITS;

  logic [1:0]           r_table [DEPTH];
  logic                 r_res_valid;
  logic                 r_res_taken;
  logic                 r_res_mispredict;
  logic [CNT_WIDTH-1:0] r_branch_cnt;
  logic [CNT_WIDTH-1:0] r_mispredict_cnt;

  logic [IDX_BITS-1:0]  w_if_idx;
  logic [IDX_BITS-1:0]  w_ex_idx;
  logic                 w_a_neg;
  logic                 w_a_zero;
  logic                 w_cond;
  logic                 w_jump;
  logic                 w_taken;
  logic                 w_mispredict;
  logic [1:0]           w_entry;
  logic [1:0]           w_entry_next;
  logic                 w_unused;

  // Word-aligned PCs: bits [1:0] never select an entry.
  assign w_if_idx = IF_PC[IDX_BITS+1:2];
  assign w_ex_idx = EX_PC[IDX_BITS+1:2];
  assign w_unused = ^{IF_PC[1:0], EX_PC[1:0], IF_PC[ADDR_WIDTH-1:IDX_BITS+2], EX_PC[ADDR_WIDTH-1:IDX_BITS+2]};

  assign IF_Predict_Taken = r_table[w_if_idx][1];

  assign w_a_neg  = EX_A[WIDTH-1];
  assign w_a_zero = (EX_A == '0);

  always_comb begin
    w_cond  = 1'b0;
    w_jump  = 1'b0;
    w_taken = 1'b0;
    case (EX_BranchType)
      4'b0011: begin w_cond = 1'b1; w_taken = !w_a_neg;               end
      4'b0100: begin w_cond = 1'b1; w_taken = (EX_A == EX_B);         end
      4'b0101: begin w_cond = 1'b1; w_taken = (EX_A != EX_B);         end
      4'b0110: begin w_cond = 1'b1; w_taken = !w_a_neg && !w_a_zero;  end
      4'b0111: begin w_cond = 1'b1; w_taken = w_a_neg || w_a_zero;    end
      4'b1000: begin w_cond = 1'b1; w_taken = w_a_neg;                end
      4'b1001: begin w_jump = 1'b1; w_taken = 1'b1;                   end
      default: ;
    endcase
    w_cond = w_cond && EX_Valid;
    w_jump = w_jump && EX_Valid;
  end

  assign w_mispredict = w_cond && (w_taken != EX_Predicted_Taken);
  assign w_entry      = r_table[w_ex_idx];

  always_comb begin
    w_entry_next = w_entry;
    if (w_taken && w_entry != 2'b11)
      w_entry_next = w_entry + 2'd1;
    else if (!w_taken && w_entry != 2'b00)
      w_entry_next = w_entry - 2'd1;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) r_table[i] <= 2'b01;
    end else if (w_cond) begin
      r_table[w_ex_idx] <= w_entry_next;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_res_valid      <= 1'b0;
      r_res_taken      <= 1'b0;
      r_res_mispredict <= 1'b0;
    end else begin
      r_res_valid      <= w_cond || w_jump;
      r_res_taken      <= w_jump || (w_cond && w_taken);
      r_res_mispredict <= w_mispredict;
    end
  end

  // Clear wins over a same-cycle increment.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else if (Cnt_Clr) begin
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else if (w_cond) begin
      r_branch_cnt <= r_branch_cnt + CNT_WIDTH'(1);
      if (w_mispredict) r_mispredict_cnt <= r_mispredict_cnt + CNT_WIDTH'(1);
    end
  end

  assign Res_Valid        = r_res_valid;
  assign Res_Taken        = r_res_taken;
  assign Res_Mispredict   = r_res_mispredict;
  assign Branch_Count     = r_branch_cnt;
  assign Mispredict_Count = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - self-checking bench for branch_predict_unit
// Directed scenarios plus a randomized stream against a behavioural model.
module tb_branch_predict_unit;
  localparam int W  = 32;
  localparam int AW = 32;
  localparam int IB = 4;
  localparam int CW = 4;

  logic          Clk = 1'b0;
  logic          Rst;
  logic [AW-1:0] IF_PC;
  logic          IF_Predict_Taken;
  logic          EX_Valid;
  logic [3:0]    EX_BranchType;
  logic [W-1:0]  EX_A, EX_B;
  logic [AW-1:0] EX_PC;
  logic          EX_Predicted_Taken;
  logic          Cnt_Clr;
  logic          Res_Valid, Res_Taken, Res_Mispredict;
  logic [CW-1:0] Branch_Count, Mispredict_Count;

  branch_predict_unit #(.WIDTH(W), .ADDR_WIDTH(AW), .IDX_BITS(IB), .CNT_WIDTH(CW)) dut (
    .Clk(Clk), .Rst(Rst), .IF_PC(IF_PC), .IF_Predict_Taken(IF_Predict_Taken),
    .EX_Valid(EX_Valid), .EX_BranchType(EX_BranchType), .EX_A(EX_A), .EX_B(EX_B),
    .EX_PC(EX_PC), .EX_Predicted_Taken(EX_Predicted_Taken), .Cnt_Clr(Cnt_Clr),
    .Res_Valid(Res_Valid), .Res_Taken(Res_Taken), .Res_Mispredict(Res_Mispredict),
    .Branch_Count(Branch_Count), .Mispredict_Count(Mispredict_Count)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;

  int m_tab [16];
  int m_bc, m_mc;
  bit e_valid, e_taken, e_mis;

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) m_tab[i] = 1;
    m_bc = 0; m_mc = 0;
    e_valid = 0; e_taken = 0; e_mis = 0;
  endfunction

  function automatic int idx_of(logic [AW-1:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic bit m_pred(logic [AW-1:0] pc);
    return m_tab[idx_of(pc)] >= 2;
  endfunction

  function automatic void m_apply(bit v, int code, int a, int b, logic [AW-1:0] pc, bit pred, bit clr);
    bit cond, jmp, tk;
    int i;
    cond = v && code >= 3 && code <= 8;
    jmp  = v && code == 9;
    case (code)
      3: tk = (a >= 0);
      4: tk = (a == b);
      5: tk = (a != b);
      6: tk = (a > 0);
      7: tk = (a <= 0);
      8: tk = (a < 0);
      default: tk = 0;
    endcase
    e_valid = cond || jmp;
    e_taken = jmp || (cond && tk);
    e_mis   = cond && (tk != pred);
    if (cond) begin
      i = idx_of(pc);
      m_tab[i] = tk ? ((m_tab[i] == 3) ? 3 : m_tab[i] + 1) : ((m_tab[i] == 0) ? 0 : m_tab[i] - 1);
      m_bc = (m_bc + 1) % 16;
      if (e_mis) m_mc = (m_mc + 1) % 16;
    end
    if (clr) begin m_bc = 0; m_mc = 0; end
  endfunction

  task automatic drive(bit v, int code, int a, int b, logic [AW-1:0] pc, bit pred, bit clr);
    @(negedge Clk);
    EX_Valid = v; EX_BranchType = 4'(code); EX_A = a; EX_B = b;
    EX_PC = pc; EX_Predicted_Taken = pred; Cnt_Clr = clr;
    m_apply(v, code, a, b, pc, pred, clr);
    @(posedge Clk);
    #1;
    EX_Valid = 0; Cnt_Clr = 0;
  endtask

  task automatic test_reset();
    Rst = 1; IF_PC = 32'h40; EX_Valid = 0; EX_BranchType = 0; EX_A = 0; EX_B = 0;
    EX_PC = 0; EX_Predicted_Taken = 0; Cnt_Clr = 0;
    m_reset();
    repeat (2) @(posedge Clk);
    @(negedge Clk); Rst = 0;
    #1;
    n_tests++;
    if (IF_Predict_Taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred got %b want 0", IF_Predict_Taken); end
    n_tests++;
    if ({Res_Valid, Res_Taken, Res_Mispredict} !== 3'b000 || Branch_Count !== 0 || Mispredict_Count !== 0) begin
      n_fail++; $display("FAIL reset_outs got %b%b%b bc=%0d mc=%0d want 000 0 0", Res_Valid, Res_Taken, Res_Mispredict, Branch_Count, Mispredict_Count);
    end
  endtask

  task automatic test_beq_mispredict();
    drive(1, 4, -9, -9, 32'h40, 0, 0);
    IF_PC = 32'h40; #1;
    n_tests++;
    if ({Res_Valid, Res_Taken, Res_Mispredict} !== 3'b111) begin
      n_fail++; $display("FAIL beq_res got %b%b%b want 111", Res_Valid, Res_Taken, Res_Mispredict);
    end
    n_tests++;
    if (Branch_Count !== 1 || Mispredict_Count !== 1) begin
      n_fail++; $display("FAIL beq_counts got %0d/%0d want 1/1", Branch_Count, Mispredict_Count);
    end
    n_tests++;
    if (IF_Predict_Taken !== 1'b1) begin n_fail++; $display("FAIL beq_pred got %b want 1", IF_Predict_Taken); end
    @(posedge Clk); #1;
    n_tests++;
    if (Res_Valid !== 1'b0) begin n_fail++; $display("FAIL beq_pulse got %b want 0", Res_Valid); end
  endtask

  task automatic test_saturation();
    int want [4] = '{2, 3, 3, 2};
    IF_PC = 32'h44;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) drive(1, 3, 47, 0, 32'h44, 1, 0);
      else       drive(1, 8, 101, 0, 32'h44, 1, 0);
      n_tests++;
      if (m_tab[1] != want[k] || IF_Predict_Taken !== 1'b1 || Res_Taken !== (k < 3)) begin
        n_fail++; $display("FAIL sat_step%0d model=%0d pred=%b taken=%b want entry %0d pred 1", k, m_tab[1], IF_Predict_Taken, Res_Taken, want[k]);
      end
    end
  endtask

  task automatic test_alias();
    drive(1, 5, 1, 1, 32'h04, 0, 0);
    drive(1, 5, 1, 1, 32'h04, 0, 0);
    IF_PC = 32'h44; #1;
    n_tests++;
    if (IF_Predict_Taken !== m_pred(32'h44) || IF_Predict_Taken !== 1'b0) begin
      n_fail++; $display("FAIL alias_pred got %b want 0", IF_Predict_Taken);
    end
  endtask

  task automatic test_jump_nonbranch();
    logic [CW-1:0] bc0, mc0;
    bc0 = 4'(m_bc); mc0 = 4'(m_mc);
    drive(1, 9, 0, 0, 32'h48, 0, 0);
    n_tests++;
    if ({Res_Valid, Res_Taken, Res_Mispredict} !== 3'b110 || Branch_Count !== bc0 || Mispredict_Count !== mc0) begin
      n_fail++; $display("FAIL jump got %b%b%b bc=%0d mc=%0d want 110 %0d %0d", Res_Valid, Res_Taken, Res_Mispredict, Branch_Count, Mispredict_Count, bc0, mc0);
    end
    drive(1, 0, 5, 5, 32'h48, 1, 0);
    n_tests++;
    if ({Res_Valid, Res_Taken, Res_Mispredict} !== 3'b000 || Branch_Count !== bc0) begin
      n_fail++; $display("FAIL nonbranch got %b%b%b bc=%0d want 000 %0d", Res_Valid, Res_Taken, Res_Mispredict, Branch_Count, bc0);
    end
  endtask

  task automatic test_back_to_back();
    IF_PC = 32'h50;
    drive(1, 6, 3, 0, 32'h50, 0, 0);
    @(negedge Clk);
    EX_Valid = 1; EX_BranchType = 4'd6; EX_A = 3; EX_PC = 32'h50; EX_Predicted_Taken = 1;
    #1;
    n_tests++;
    if (IF_Predict_Taken !== m_pred(32'h50)) begin
      n_fail++; $display("FAIL b2b_old got %b want %b", IF_Predict_Taken, m_pred(32'h50));
    end
    m_apply(1, 6, 3, 0, 32'h50, 1, 0);
    @(posedge Clk); #1; EX_Valid = 0;
    n_tests++;
    if (IF_Predict_Taken !== m_pred(32'h50) || m_tab[4] != 3 || Res_Mispredict !== 1'b0) begin
      n_fail++; $display("FAIL b2b_new got pred %b mis %b want 1 0", IF_Predict_Taken, Res_Mispredict);
    end
  endtask

  task automatic test_random();
    int codes [10] = '{3, 4, 5, 6, 7, 8, 9, 0, 2, 15};
    int a, b;
    logic [AW-1:0] pc;
    for (int k = 0; k < 80; k++) begin
      a  = $urandom_range(0, 3) == 0 ? 0 : int'($urandom_range(0, 40)) - 20;
      b  = $urandom_range(0, 1) == 0 ? a : int'($urandom_range(0, 40)) - 20;
      pc = {$urandom_range(0, 255), 8'h00} | AW'($urandom_range(0, 15) * 4);
      IF_PC = AW'($urandom_range(0, 15) * 4);
      drive($urandom_range(0, 5) != 0, codes[$urandom_range(0, 9)], a, b, pc,
            1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
      n_tests++;
      if (Res_Valid !== e_valid || Res_Taken !== e_taken || Res_Mispredict !== e_mis ||
          Branch_Count !== 4'(m_bc) || Mispredict_Count !== 4'(m_mc) || IF_Predict_Taken !== m_pred(IF_PC)) begin
        n_fail++;
        $display("FAIL rand%0d got %b%b%b bc=%0d mc=%0d pred=%b want %b%b%b %0d %0d %b", k,
                 Res_Valid, Res_Taken, Res_Mispredict, Branch_Count, Mispredict_Count, IF_Predict_Taken,
                 e_valid, e_taken, e_mis, m_bc, m_mc, m_pred(IF_PC));
      end
    end
  endtask

  task automatic test_wrap();
    drive(0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 16; k++) drive(1, 5, k, k + 1, 32'h60, 0, 0);
    n_tests++;
    if (Branch_Count !== 0 || Mispredict_Count !== 0 || m_bc != 0) begin
      n_fail++; $display("FAIL wrap got %0d/%0d want 0/0", Branch_Count, Mispredict_Count);
    end
  endtask

  task automatic test_clear();
    drive(1, 5, 1, 2, 32'h60, 0, 0);
    IF_PC = 32'h64;
    drive(1, 4, 7, 7, 32'h64, 0, 1);
    n_tests++;
    if (Branch_Count !== 0 || Mispredict_Count !== 0 || IF_Predict_Taken !== 1'b1 || Res_Mispredict !== 1'b1) begin
      n_fail++; $display("FAIL clear got %0d/%0d pred %b mis %b want 0/0 1 1", Branch_Count, Mispredict_Count, IF_Predict_Taken, Res_Mispredict);
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 4, 2, 2, 32'h44, 0, 0);
    @(negedge Clk);
    EX_Valid = 1; EX_BranchType = 4'd4; EX_A = 3; EX_B = 3; EX_PC = 32'h44; EX_Predicted_Taken = 0;
    #2 Rst = 1;
    #1;
    m_reset();
    n_tests++;
    if (Res_Valid !== 1'b0 || Branch_Count !== 0 || Mispredict_Count !== 0) begin
      n_fail++; $display("FAIL rst_async got v=%b bc=%0d mc=%0d want 0 0 0", Res_Valid, Branch_Count, Mispredict_Count);
    end
    @(negedge Clk); Rst = 0; EX_Valid = 0;
    for (int k = 0; k < 16; k++) begin
      IF_PC = AW'(k * 4); #1;
      n_tests++;
      if (IF_Predict_Taken !== 1'b0) begin n_fail++; $display("FAIL rst_table%0d got %b want 0", k, IF_Predict_Taken); end
    end
    @(posedge Clk); #1;
    n_tests++;
    if (Res_Valid !== 1'b0 || Branch_Count !== 0) begin
      n_fail++; $display("FAIL rst_discard got v=%b bc=%0d want 0 0", Res_Valid, Branch_Count);
    end
  endtask

  initial begin
    test_reset();
    test_beq_mispredict();
    test_saturation();
    test_alias();
    test_jump_nonbranch();
    test_back_to_back();
    test_random();
    test_wrap();
    test_clear();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
